uart_stim_tx: RTL and testbench
===============================

# uart_stim_tx

Serial UART transmitter that drives the core's `UART_RXD` line in the product-construction verification harness. It accepts bytes over a valid/ready interface and buffers them in a small FIFO. Each byte is serialised as an 8N1 frame (optionally 8E1) at a fixed baud divisor. One instance feeds both the left and right core copies, so their receive stimulus is identical.

## Interface
Parameters:
- `BAUD_DIV`, 868: XCLK cycles per bit. Must be ≥ 2.
- `FIFO_DEPTH`, 4: byte buffer entries. Must be a power of two, ≥ 2.

Ports:
- `XCLK` in 1: single clock, rising edge.
- `XRES` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO can accept a byte (not full).
- `UART_TXD` out 1: serial line, idle high. Connects to the core's `UART_RXD`.
- `busy` out 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count` out `$clog2(FIFO_DEPTH+1)`: number of bytes currently buffered.

## Operation
- Push: a byte is written to the FIFO on any rising edge where `tx_valid && tx_ready`.
- `tx_ready` = !full, decoded combinationally from the count.
  - When full, no push is accepted, even if a pop happens in the same cycle.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves `fifo_count` unchanged.
- Read/write pointers are `log2(FIFO_DEPTH)` bits wide and wrap modulo `FIFO_DEPTH`.
- FSM states:
  - IDLE: `UART_TXD`=1. If the FIFO is non-empty, pop the head into the shift register, load `bit_cnt`=0, go to START.
  - START: `UART_TXD`=0 for `BAUD_DIV` cycles, then go to DATA.
  - DATA: `UART_TXD`=shift[0] for `BAUD_DIV` cycles, then shift right and increment `bit_cnt`.
    - After bit 7, go to PARITY (if enabled) or STOP.
  - PARITY: `UART_TXD`=^byte (even parity) for `BAUD_DIV` cycles, then go to STOP.
  - STOP: `UART_TXD`=1 for `BAUD_DIV` cycles.
    - On the last cycle of STOP: if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter:
  - Width `$clog2(BAUD_DIV)`; counts 0..`BAUD_DIV`-1.
  - Reloads to 0 on every bit boundary and on entry to START.
- `UART_TXD` is driven from a flop (glitch-free).
- `busy` = (state != IDLE) || (`fifo_count` != 0).

## Timing
- Reset values:
  - `UART_TXD`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0.
  - FSM=IDLE; pointers and counters = 0.
- Reset asserted mid-frame: the line returns high immediately (asynchronously), the FIFO is flushed, and the partial frame is discarded.
- Latency, with the FSM in IDLE and the FIFO empty:
  - Byte accepted at edge E0 → `fifo_count`=1 after E0.
  - Popped at E1 → `UART_TXD` falls after E1 and `fifo_count` returns to 0.
- Frame length:
  - 10·`BAUD_DIV` cycles without parity.
  - 11·`BAUD_DIV` cycles with parity.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Throughput: `FIFO_DEPTH` bytes can be queued while a frame is in progress.
  - `tx_ready` returns high on the edge after the pop that frees an entry.

## Configuration
- `UART_STIM_PARITY_EN` defined:
  - The PARITY state is compiled in; frames are 8E1.
  - The parity bit is the XOR of the 8 data bits, sent between bit 7 and stop.
- `UART_STIM_PARITY_EN` undefined:
  - The PARITY state and its logic are absent; frames are 8N1.

## Test plan
- Reset, then idle 50 cycles → `UART_TXD`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0 throughout.
- `BAUD_DIV`=4, push 0x55 once, no parity → `UART_TXD` falls 1 cycle after acceptance.
  - Line then holds 0,1,0,1,0,1,0,1,0,1 for 4 cycles each (40 cycles total).
  - `busy` drops the cycle after the stop bit ends.
- `BAUD_DIV`=4, parity enabled, push 0x07 → data bits 1,1,1,0,0,0,0,0, then parity=1, then stop=1. Frame length 44 cycles.
- Push 5 bytes 0xA0..0xA4 with `tx_valid` held high, `FIFO_DEPTH`=4:
  - First byte is popped, 4 are queued, `tx_ready`=0 while `fifo_count`=4.
  - All 5 frames go out contiguously with no idle cycles between stop and start.
  - Bytes are sent in order.
- Assert `XRES` low during data bit 3 of 0xFF with 2 bytes queued:
  - `UART_TXD`=1 and `fifo_count`=0 immediately.
  - After release, no residual frame is sent.
- FIFO full, pop at the end of STOP while `tx_valid`=1 on the same edge → push is rejected.
  - `fifo_count` goes 4→3.
  - Push is accepted on the next edge; count returns to 4.

Source files
------------

// File: rtl/uart_stim_tx.sv
`default_nettype none
// ============================================================================
// uart_stim_tx : FIFO-buffered UART transmitter, 8N1 (8E1 with UART_STIM_PARITY_EN)
// Revision     : 1.0
// ============================================================================
module uart_stim_tx #(
    parameter int BAUD_DIV   = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               XCLK,
    input  logic                               XRES,
    input  logic [7:0]                         tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               UART_TXD,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [BW-1:0] c_baud_last  = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] c_count_full = CW'(FIFO_DEPTH);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_stop   = 3'd3;
`ifdef UART_STIM_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd4;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_not_empty;
    logic [7:0]    w_head;

    // Transmit FSM
    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          w_bit_end;
`ifdef UART_STIM_PARITY_EN
    logic          par_q, par_d;
`endif

    assign w_full      = (count_q == c_count_full);
    assign w_not_empty = (count_q != '0);
    assign w_push      = tx_valid && !w_full;
    assign w_head      = mem_q[rd_ptr_q];
    assign w_bit_end   = (baud_q == c_baud_last);

    assign tx_ready    = !w_full;
    assign fifo_count  = count_q;
    assign busy        = (state_q != c_st_idle) || w_not_empty;
    assign UART_TXD    = txd_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge XCLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FSM state register; txd_q resets high so the line idles immediately
    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_q <= c_st_idle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
`ifdef UART_STIM_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef UART_STIM_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; both IDLE and the final STOP cycle pop into START
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        w_pop   = 1'b0;
`ifdef UART_STIM_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            c_st_idle: begin
                if (w_not_empty) begin
                    w_pop   = 1'b1;
                    shift_d = w_head;
                    bit_d   = 3'd0;
                    baud_d  = '0;
                    state_d = c_st_start;
`ifdef UART_STIM_PARITY_EN
                    par_d   = ^w_head;
`endif
                end
            end
            c_st_start: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    state_d = c_st_data;
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
            c_st_data: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_STIM_PARITY_EN
                        state_d = c_st_parity;
`else
                        state_d = c_st_stop;
`endif
                    end
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
`ifdef UART_STIM_PARITY_EN
            c_st_parity: begin
                if (w_bit_end) begin
                    baud_d  = '0;
                    state_d = c_st_stop;
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
`endif
            c_st_stop: begin
                if (w_bit_end) begin
                    baud_d = '0;
                    if (w_not_empty) begin
                        w_pop   = 1'b1;
                        shift_d = w_head;
                        bit_d   = 3'd0;
                        state_d = c_st_start;
`ifdef UART_STIM_PARITY_EN
                        par_d   = ^w_head;
`endif
                    end else begin
                        state_d = c_st_idle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = c_st_idle;
                baud_d  = '0;
            end
        endcase
    end

    // Line level is registered from the upcoming state so it changes with the state
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            c_st_start: txd_d = 1'b0;
            c_st_data:  txd_d = shift_d[0];
`ifdef UART_STIM_PARITY_EN
            c_st_parity: txd_d = par_d;
`endif
            default:    txd_d = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_stim_tx.sv
`default_nettype none
// Scoreboard bench for uart_stim_tx: queued expected bytes, frame-decoding monitor.
module tb_uart_stim_tx;
    localparam int BD    = 4;
    localparam int DEPTH = 4;
`ifdef UART_STIM_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BD;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] sb[$];
    int         starts[$];

    uart_stim_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .XCLK       (clk),
        .XRES       (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .UART_TXD   (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_STIM_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold tx_valid high and push nbytes consecutive values starting at first
    task automatic send_held(input logic [7:0] first, input int nbytes);
        int   i = 0;
        int   guard = 0;
        logic rdy;
        tx_valid = 1'b1;
        tx_data  = first;
        while (i < nbytes && guard < 1000) begin
            @(negedge clk);
            rdy = tx_ready;
            tick();
            guard++;
            if (rdy) begin
                sb.push_back(tx_data);
                i++;
                tx_data = first + 8'(i);
            end
        end
        check("send_held_timeout", 32'(i), 32'(nbytes));
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n < bound), 32'd1);
    endtask

    // Monitor: decode each frame cycle by cycle against the queued byte
    initial begin : monitor
        logic [7:0] exp_b;
        logic [7:0] got;
        logic       have;
        logic       ok;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rst_n && txd === 1'b0) begin
                starts.push_back(cyc);
                have  = (sb.size() != 0);
                exp_b = 8'h00;
                if (have) exp_b = sb.pop_front();
                ok = 1'b1;
                aborted = 1'b0;
                got = 8'h00;
                for (int b = 0; b < NBITS && !aborted; b++) begin
                    for (int k = 0; k < BD && !aborted; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                        end else begin
                            if (txd !== frame_bit(exp_b, b)) ok = 1'b0;
                            if (b >= 1 && b <= 8 && k == BD / 2) got[b-1] = txd;
                        end
                    end
                end
                if (!aborted) begin
                    if (!have) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_frame: got byte %02h, expected none", got);
                    end else begin
                        check("frame_byte", 32'(got), 32'(exp_b));
                        check("frame_shape", 32'(ok), 32'd1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   n;
        logic low_seen;
        repeat (3) tick();
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_state", 32'({txd, tx_ready, busy, fifo_count}), 32'(6'b110_000));
        end
        tick();

        // Single byte 0x55: latency and busy drop
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        sb.push_back(8'h55);
        tick();
        tx_valid = 1'b0;
        check("accept_count", 32'(fifo_count), 32'd1);
        check("accept_line_high", 32'(txd), 32'd1);
        tick();
        check("pop_line_low", 32'(txd), 32'd0);
        check("pop_count", 32'(fifo_count), 32'd0);
        check("pop_busy", 32'(busy), 32'd1);
        repeat (FRAME - 1) tick();
        check("busy_last_stop", 32'(busy), 32'd1);
        tick();
        check("busy_drop", 32'(busy), 32'd0);
        check("line_idle", 32'(txd), 32'd1);

        // Single byte 0x07: frame length
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        sb.push_back(8'h07);
        tick();
        tx_valid = 1'b0;
        tick();
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("frame_len", 32'(n), 32'(FRAME));

        // Burst of five with tx_valid held: full FIFO and contiguous frames
        starts.delete();
        send_held(8'hA0, 5);
        tx_valid = 1'b0;
        check("burst_count_full", 32'(fifo_count), 32'd4);
        check("burst_ready_low", 32'(tx_ready), 32'd0);
        wait_idle(1000);
        check("burst_frames", 32'(starts.size()), 32'd5);
        for (int i = 1; i < 5 && i < starts.size(); i++) begin
            check("burst_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));
        end

        // Reset during data bit 3 of 0xFF with two bytes queued
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        sb.push_back(8'hFF);
        tick();
        tx_data = 8'h11;
        sb.push_back(8'h11);
        tick();
        tx_data = 8'h22;
        sb.push_back(8'h22);
        tick();
        tx_valid = 1'b0;
        repeat (15) tick();
        check("pre_reset_count", 32'(fifo_count), 32'd2);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_line_high", 32'(txd), 32'd1);
        check("reset_count", 32'(fifo_count), 32'd0);
        check("reset_ready", 32'(tx_ready), 32'd1);
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        starts.delete();
        low_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) low_seen = 1'b1;
        end
        tick();
        check("no_residual_line", 32'(low_seen), 32'd0);
        check("no_residual_frames", 32'(starts.size()), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Full FIFO: pop at end of STOP rejects a same-edge push
        starts.delete();
        send_held(8'hB0, 5);
        repeat (FRAME - 4) tick();
        check("full_before_pop", 32'(fifo_count), 32'd4);
        check("ready_before_pop", 32'(tx_ready), 32'd0);
        tick();
        check("pop_rejects_push", 32'(fifo_count), 32'd3);
        check("ready_after_pop", 32'(tx_ready), 32'd1);
        tick();
        check("push_next_edge", 32'(fifo_count), 32'd4);
        sb.push_back(8'hB5);
        tx_valid = 1'b0;
        wait_idle(1500);
        check("full_frames", 32'(starts.size()), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
